// File: rtl/lif_cfg_pkg.sv
// Shared types and constants for the LIF neuron parameter loader:
// FSM states, payload byte map, committed-parameter bundle and reset values.
package lif_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int NUM_PAYLOAD = 5;

  localparam logic [2:0] IDX_WEIGHT = 3'd0;
  localparam logic [2:0] IDX_LEAK1  = 3'd1;
  localparam logic [2:0] IDX_LEAK2  = 3'd2;
  localparam logic [2:0] IDX_THRESH = 3'd3;
  localparam logic [2:0] IDX_CYCLES = 3'd4;
  localparam logic [2:0] IDX_CSUM   = 3'd5;

  typedef logic [NUM_PAYLOAD-1:0][7:0] payload_t;

  typedef struct packed {
    logic [2:0] weight_a;
    logic [7:0] leak_rate_1;
    logic [7:0] leak_rate_2;
    logic [7:0] threshold;
    logic [3:0] leak_cycles_1;
    logic [3:0] leak_cycles_2;
  } params_t;

  localparam params_t  PARAMS_RST  = '0;
  localparam payload_t PAYLOAD_RST = '0;

  // Maps the five shadow bytes onto the neuron's parameter fields.
  function automatic params_t decode_payload(input payload_t p);
    params_t r;
    r.weight_a      = p[IDX_WEIGHT][2:0];
    r.leak_rate_1   = p[IDX_LEAK1];
    r.leak_rate_2   = p[IDX_LEAK2];
    r.threshold     = p[IDX_THRESH];
    r.leak_cycles_1 = p[IDX_CYCLES][3:0];
    r.leak_cycles_2 = p[IDX_CYCLES][7:4];
    return r;
  endfunction

endpackage

// File: rtl/lif_cfg_timeout_timer.sv
// Saturating 8-bit idle counter; expire fires on the increment that
// makes the count reach LIMIT (LIMIT == 0 disables it).
module lif_cfg_timeout_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  assign expire = en && !clr && (LIMIT != 8'd0) && (count_q == (LIMIT - 8'd1));

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lif_param_loader.sv
// Receives a framed 5-byte parameter packet plus XOR checksum and commits it
// atomically to the neuron; failed or aborted loads leave outputs untouched.
module lif_param_loader
  import lif_cfg_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       byte_valid,
  input  logic [7:0] data_in,
  output logic [2:0] weight_a,
  output logic [7:0] leak_rate_1,
  output logic [7:0] leak_rate_2,
  output logic [7:0] threshold,
  output logic [3:0] leak_cycles_1,
  output logic [3:0] leak_cycles_2,
  output logic       params_ready,
  output logic       params_updated,
  output logic       load_busy,
  output logic       load_error
);

  state_e   state_q,   state_d;
  logic [2:0] idx_q,   idx_d;
  logic [7:0] csum_q,  csum_d;
  payload_t shadow_q,  shadow_d;
  params_t  params_q,  params_d;
  logic     ready_q,   ready_d;
  logic     updated_q, updated_d;
  logic     error_q,   error_d;
  logic     tmr_clr,   tmr_en, tmr_expire;

  lif_cfg_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    shadow_d  = shadow_q;
    params_d  = params_q;
    ready_d   = ready_q;
    updated_d = 1'b0;
    error_d   = error_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = RECV;
          idx_d   = 3'd0;
          csum_d  = 8'd0;
          tmr_clr = 1'b1;
          error_d = 1'b0;
        end
      end

      RECV: begin
        // A restart outranks a byte arriving in the same cycle.
        if (load_start) begin
          idx_d   = 3'd0;
          csum_d  = 8'd0;
          tmr_clr = 1'b1;
          error_d = 1'b0;
        end else if (byte_valid) begin
          tmr_clr = 1'b1;
          if (idx_q != IDX_CSUM) begin
            shadow_d[idx_q] = data_in;
            csum_d          = csum_q ^ data_in;
            idx_d           = idx_q + 3'd1;
          end else if ((data_in == csum_q) && (shadow_q[IDX_THRESH] != 8'd0)) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
      end

      COMMIT: begin
        params_d  = decode_payload(shadow_q);
        ready_d   = 1'b1;
        updated_d = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      csum_q    <= 8'd0;
      // NOTE: the shadow bank is small and must read as zero after reset,
      // so it is reset like any other register rather than left as RAM.
      shadow_q  <= PAYLOAD_RST;
      params_q  <= PARAMS_RST;
      ready_q   <= 1'b0;
      updated_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      shadow_q  <= shadow_d;
      params_q  <= params_d;
      ready_q   <= ready_d;
      updated_q <= updated_d;
      error_q   <= error_d;
    end
  end

  assign weight_a       = params_q.weight_a;
  assign leak_rate_1    = params_q.leak_rate_1;
  assign leak_rate_2    = params_q.leak_rate_2;
  assign threshold      = params_q.threshold;
  assign leak_cycles_1  = params_q.leak_cycles_1;
  assign leak_cycles_2  = params_q.leak_cycles_2;
  assign params_ready   = ready_q;
  assign params_updated = updated_q;
  assign load_busy      = (state_q != IDLE);
  assign load_error     = error_q;

endmodule

// File: tb/tb_lif_param_loader.sv
// Self-checking bench for lif_param_loader: directed packets followed by
// randomized packets/faults, compared against a packet-level outcome model.
module tb_lif_param_loader;

  localparam logic [7:0] TMO = 8'd16;
  typedef logic [7:0] pkt_t [6];

  logic       clk = 1'b0;
  logic       reset, load_start, byte_valid;
  logic [7:0] data_in;
  logic [2:0] weight_a;
  logic [7:0] leak_rate_1, leak_rate_2, threshold;
  logic [3:0] leak_cycles_1, leak_cycles_2;
  logic       params_ready, params_updated, load_busy, load_error;

  lif_param_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .byte_valid     (byte_valid),
    .data_in        (data_in),
    .weight_a       (weight_a),
    .leak_rate_1    (leak_rate_1),
    .leak_rate_2    (leak_rate_2),
    .threshold      (threshold),
    .leak_cycles_1  (leak_cycles_1),
    .leak_cycles_2  (leak_cycles_2),
    .params_ready   (params_ready),
    .params_updated (params_updated),
    .load_busy      (load_busy),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the neuron should currently see.
  logic [2:0] m_w;
  logic [7:0] m_l1, m_l2, m_th;
  logic [3:0] m_c1, m_c2;
  logic       m_ready, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = '0; m_l1 = '0; m_l2 = '0; m_th = '0; m_c1 = '0; m_c2 = '0;
    m_ready = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_commit(input pkt_t p);
    m_w  = p[0][2:0];
    m_l1 = p[1];
    m_l2 = p[2];
    m_th = p[3];
    m_c1 = p[4][3:0];
    m_c2 = p[4][7:4];
    m_ready = 1'b1;
  endtask

  function automatic logic pkt_ok(input pkt_t p);
    logic [7:0] x;
    x = p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4];
    return (p[5] == x) && (p[3] != 8'd0);
  endfunction

  task automatic check_all(input string tag, input logic exp_busy, input logic exp_upd);
    check({tag, ".weight_a"},      32'(weight_a),       32'(m_w));
    check({tag, ".leak_rate_1"},   32'(leak_rate_1),    32'(m_l1));
    check({tag, ".leak_rate_2"},   32'(leak_rate_2),    32'(m_l2));
    check({tag, ".threshold"},     32'(threshold),      32'(m_th));
    check({tag, ".leak_cycles_1"}, 32'(leak_cycles_1),  32'(m_c1));
    check({tag, ".leak_cycles_2"}, 32'(leak_cycles_2),  32'(m_c2));
    check({tag, ".params_ready"},  32'(params_ready),   32'(m_ready));
    check({tag, ".load_error"},    32'(load_error),     32'(m_err));
    check({tag, ".load_busy"},     32'(load_busy),      32'(exp_busy));
    check({tag, ".params_updated"},32'(params_updated), 32'(exp_upd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    load_start = 1'b0;
    byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start(input string tag);
    load_start = 1'b1;
    byte_valid = 1'b0;
    tick();
    load_start = 1'b0;
    m_err = 1'b0;
    check({tag, ".start_busy"},  32'(load_busy),  32'd1);
    check({tag, ".start_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    data_in    = b;
    tick();
    byte_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  // Sends all six bytes with random idle gaps strictly shorter than the timeout.
  task automatic send_body(input pkt_t p, input int max_gap);
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(max_gap, 0));
      send_byte(p[i]);
    end
  endtask

  // Called right after the checksum byte has been sampled.
  task automatic finish_packet(input pkt_t p, input string tag);
    if (pkt_ok(p)) begin
      check_all({tag, ".commit_cyc"}, 1'b1, 1'b0);
      tick();
      model_commit(p);
      check_all({tag, ".applied"}, 1'b0, 1'b1);
      tick();
      check({tag, ".pulse_end"}, 32'(params_updated), 32'd0);
    end else begin
      m_err = 1'b1;
      check_all({tag, ".rejected"}, 1'b0, 1'b0);
      tick();
      check({tag, ".no_pulse"}, 32'(params_updated), 32'd0);
    end
  endtask

  task automatic run_packet(input pkt_t p, input int max_gap, input string tag);
    pulse_start(tag);
    send_body(p, max_gap);
    finish_packet(p, tag);
  endtask

  task automatic run_timeout(input int k, input string tag);
    pulse_start(tag);
    for (int i = 0; i < k; i++) send_byte(8'($urandom));
    idle(int'(TMO) - 1);
    check({tag, ".still_busy"}, 32'(load_busy), 32'd1);
    idle(1);
    m_err = 1'b1;
    check_all({tag, ".expired"}, 1'b0, 1'b0);
    send_byte(8'($urandom));
    check_all({tag, ".late_byte"}, 1'b0, 1'b0);
  endtask

  task automatic run_restart(input int k, input pkt_t p, input string tag);
    pulse_start(tag);
    for (int i = 0; i < k; i++) send_byte(8'($urandom));
    load_start = 1'b1;
    byte_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    m_err = 1'b0;
    check({tag, ".restart_busy"}, 32'(load_busy), 32'd1);
    send_body(p, 3);
    finish_packet(p, tag);
  endtask

  function automatic pkt_t rand_pkt(input int kind);
    pkt_t p;
    for (int i = 0; i < 5; i++) p[i] = 8'($urandom);
    if (kind == 2) p[3] = 8'h00;
    else if (p[3] == 8'h00) p[3] = 8'h01;
    p[5] = p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4];
    if (kind == 1) p[5] = p[5] ^ 8'(1 << $urandom_range(7, 0));
    return p;
  endfunction

  pkt_t p1, p_bad, p_zero, pr;

  initial begin
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; data_in = 8'h00;
    model_reset();
    p1     = '{8'h05, 8'h02, 8'h01, 8'h80, 8'h31, 8'hB7};
    p_bad  = '{8'h05, 8'h02, 8'h01, 8'h80, 8'h31, 8'hB6};
    p_zero = '{8'h05, 8'h02, 8'h01, 8'h00, 8'h31, 8'h37};

    tick(); tick();
    check_all("reset", 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Bytes in IDLE must be ignored.
    send_byte(8'h5A);
    check_all("idle_byte", 1'b0, 1'b0);

    run_packet(p1, 0, "t1_valid");
    check({"t1.weight_a_direct"}, 32'(weight_a), 32'd5);
    check({"t1.threshold_direct"}, 32'(threshold), 32'd128);
    run_packet(p_bad, 0, "t2_badcsum");
    run_packet(p_zero, 0, "t3_zero_thr");
    run_timeout(2, "t4_timeout");
    run_restart(3, p1, "t5_restart");

    // Async reset between edges after byte 3.
    pulse_start("t6");
    send_byte(p1[0]); send_byte(p1[1]); send_byte(p1[2]);
    #3 reset = 1'b1;
    #1 model_reset();
    check_all("t6_async_reset", 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_packet(p1, 2, "t6_after");

    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(4, 0);
      pr = rand_pkt(kind);
      case (kind)
        3:       run_timeout($urandom_range(5, 0), $sformatf("rnd%0d_tmo", it));
        4:       run_restart($urandom_range(5, 0), pr, $sformatf("rnd%0d_rst", it));
        default: run_packet(pr, int'(TMO) - 1, $sformatf("rnd%0d_pkt", it));
      endcase
      idle($urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
